// File: rtl/bpc_pkg.sv
// Shared types and defaults for the BPC decompressor arbiter.
package bpc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    localparam int unsigned BPC_DATA_W    = 64;
    localparam int unsigned BPC_BLK_BEATS = 16;
    localparam int unsigned BPC_STAT_W    = 16;

endpackage

// File: rtl/bpc_rr_pick.sv
// Rotating-priority encoder: first asserted request at or after rr_ptr, wrapping to 0.
module bpc_rr_pick #(
    parameter  int unsigned NUM_CH = 4,
    localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   rr_ptr,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_vld
);

    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_CH;
            if (!gnt_vld && req[CH_W'(idx)]) begin
                gnt_vld = 1'b1;
                gnt_idx = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bpc_decomp_arb.sv
// Packet-granular round-robin arbiter sharing one BPC decompressor among NUM_CH streams.
// Optional per-channel completed-packet counters under `define BPC_ARB_STATS_EN.
module bpc_decomp_arb
    import bpc_pkg::*;
#(
    parameter  int unsigned NUM_CH    = 4,
    parameter  int unsigned DATA_W    = BPC_DATA_W,
    parameter  int unsigned BLK_BEATS = BPC_BLK_BEATS,
    localparam int unsigned CH_W      = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        s_valid,
    input  logic [NUM_CH*DATA_W-1:0] s_data,
    input  logic [NUM_CH-1:0]        s_sop,
    input  logic [NUM_CH-1:0]        s_eop,
    output logic [NUM_CH-1:0]        s_ready,
    output logic                     dc_valid,
    output logic [DATA_W-1:0]        dc_data,
    output logic                     dc_sop,
    output logic                     dc_eop,
    input  logic                     dc_ready,
    input  logic                     dco_valid,
    input  logic [DATA_W-1:0]        dco_data,
    input  logic                     dco_sop,
    input  logic                     dco_eop,
    output logic                     dco_ready,
    output logic [NUM_CH-1:0]        m_valid,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_sop,
    output logic                     m_eop,
    input  logic [NUM_CH-1:0]        m_ready,
    output logic                     busy,
    output logic [CH_W-1:0]          owner,
    output logic                     err_drop
`ifdef BPC_ARB_STATS_EN
    ,
    input  logic [CH_W-1:0]          stat_sel,
    output logic [BPC_STAT_W-1:0]    stat_cnt
`endif
);

    if (NUM_CH < 2 || NUM_CH > 8 || BLK_BEATS < 2) begin : g_cfg_err
        $error("bpc_decomp_arb: unsupported NUM_CH or BLK_BEATS");
    end

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   owner_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              err_drop_d;
    logic [NUM_CH-1:0] req, stray;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_vld;

    assign req   = s_valid & s_sop;
    assign stray = s_valid & ~s_sop;

    bpc_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // State, grant and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner    <= '0;
            rr_ptr_q <= '0;
            busy     <= 1'b0;
            err_drop <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner    <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            busy     <= (state_d != IDLE);
            err_drop <= err_drop_d;
        end
    end

    // Next state and datapath steering
    always_comb begin
        logic found;
        logic route_out;
        state_d    = state_q;
        owner_d    = owner;
        rr_ptr_d   = rr_ptr_q;
        err_drop_d = 1'b0;
        found      = 1'b0;
        route_out  = 1'b0;
        s_ready    = '0;
        dc_valid   = 1'b0;
        dc_data    = '0;
        dc_sop     = 1'b0;
        dc_eop     = 1'b0;
        dco_ready  = 1'b0;
        m_valid    = '0;
        m_data     = '0;
        m_sop      = 1'b0;
        m_eop      = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    owner_d = gnt_idx;
                    state_d = FEED;
                end else begin
                    // Orphan beats are only discarded when no packet is waiting
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (!found && stray[i]) begin
                            s_ready[i] = 1'b1;
                            found      = 1'b1;
                        end
                    end
                    err_drop_d = found;
                end
            end
            FEED: begin
                dc_valid         = s_valid[owner];
                dc_data          = s_data[32'(owner)*DATA_W +: DATA_W];
                dc_sop           = s_sop[owner];
                dc_eop           = s_eop[owner];
                s_ready[owner]   = dc_ready;
                route_out        = 1'b1;
                if (s_valid[owner] && dc_ready && s_eop[owner]) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                route_out = 1'b1;
                if (dco_valid && m_ready[owner] && dco_eop) begin
                    state_d  = IDLE;
                    rr_ptr_d = (owner == CH_W'(NUM_CH - 1)) ? '0 : owner + CH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Early decompressor output during FEED is routed like DRAIN
        if (route_out) begin
            m_valid[owner] = dco_valid;
            m_data         = dco_data;
            m_sop          = dco_sop;
            m_eop          = dco_eop;
            dco_ready      = m_ready[owner];
        end
    end

`ifdef BPC_ARB_STATS_EN
    logic                  pkt_done;
    logic [BPC_STAT_W-1:0] stat_q [NUM_CH];

    assign pkt_done = (state_q == DRAIN) && dco_valid && m_ready[owner] && dco_eop;

    // Saturating completed-packet counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                stat_q[i] <= '0;
            end
        end else if (pkt_done && (stat_q[owner] != {BPC_STAT_W{1'b1}})) begin
            stat_q[owner] <= stat_q[owner] + BPC_STAT_W'(1);
        end
    end

    assign stat_cnt = stat_q[stat_sel];
`endif

endmodule

// File: tb/tb_bpc_decomp_arb.sv
// Scoreboard bench for bpc_decomp_arb with a behavioural decompressor model.
module tb_bpc_decomp_arb;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned BLK    = 16;
    localparam int unsigned CH_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_CH-1:0]        s_valid, s_sop, s_eop, s_ready;
    logic [NUM_CH*DATA_W-1:0] s_data;
    logic                     dc_valid, dc_sop, dc_eop, dc_ready;
    logic [DATA_W-1:0]        dc_data;
    logic                     dco_valid, dco_sop, dco_eop, dco_ready;
    logic [DATA_W-1:0]        dco_data;
    logic [NUM_CH-1:0]        m_valid, m_ready;
    logic [DATA_W-1:0]        m_data;
    logic                     m_sop, m_eop, busy, err_drop;
    logic [CH_W-1:0]          owner;
`ifdef BPC_ARB_STATS_EN
    logic [CH_W-1:0]          stat_sel = '0;
    logic [15:0]              stat_cnt;
`endif

    bpc_decomp_arb #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .BLK_BEATS(BLK)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_data(s_data), .s_sop(s_sop), .s_eop(s_eop), .s_ready(s_ready),
        .dc_valid(dc_valid), .dc_data(dc_data), .dc_sop(dc_sop), .dc_eop(dc_eop), .dc_ready(dc_ready),
        .dco_valid(dco_valid), .dco_data(dco_data), .dco_sop(dco_sop), .dco_eop(dco_eop),
        .dco_ready(dco_ready),
        .m_valid(m_valid), .m_data(m_data), .m_sop(m_sop), .m_eop(m_eop), .m_ready(m_ready),
        .busy(busy), .owner(owner), .err_drop(err_drop)
`ifdef BPC_ARB_STATS_EN
        , .stat_sel(stat_sel), .stat_cnt(stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [63:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    beat_t src_q[$];
    beat_t exp_dc[$];
    beat_t exp_out[$];
    int    exp_gnt[$];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned dc_cnt = 0;
    int unsigned out_cnt = 0;
    int unsigned pkt_no = 0;
    logic [NUM_CH-1:0] src_hs = '0;
    logic busy_prev = 1'b0;
    logic dc_rdy_knob = 1'b1;
    logic m_rdy = 1'b1;
    logic mr_toggle = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] dmodel(input logic [63:0] seed, input int k);
        return seed ^ (64'h9E3779B97F4A7C15 * 64'(k + 1)) ^ {32'(k), 32'(k)};
    endfunction

    // Decompressor model: absorbs a compressed packet, then emits BLK beats derived from its first beat
    logic        dm_active;
    logic [4:0]  dm_k;
    logic [63:0] dm_seed;

    assign dc_ready  = ~dm_active & dc_rdy_knob;
    assign dco_valid = dm_active;
    assign dco_data  = dmodel(dm_seed, int'(dm_k));
    assign dco_sop   = dm_active && (dm_k == 5'd0);
    assign dco_eop   = dm_active && (dm_k == 5'(BLK - 1));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_active <= 1'b0;
            dm_k      <= '0;
            dm_seed   <= '0;
        end else begin
            if (dc_valid && dc_ready) begin
                if (dc_sop) dm_seed <= dc_data;
                if (dc_eop) begin
                    dm_active <= 1'b1;
                    dm_k      <= '0;
                end
            end
            if (dm_active && dco_ready) begin
                if (dm_k == 5'(BLK - 1)) dm_active <= 1'b0;
                dm_k <= dm_k + 5'd1;
            end
        end
    end

    // Monitor: sample mid-cycle, compare against scoreboard
    always @(negedge clk) begin
        beat_t e;
        src_hs = s_valid & s_ready;
        if (rst_n) begin
            check("s_ready_onehot0", 64'($onehot0(s_ready)), 64'd1);
            if (busy) check("s_ready_non_owner", 64'(s_ready & ~(4'b0001 << owner)), 64'd0);
            if (busy && !busy_prev) begin
                if (exp_gnt.size() == 0) check("grant_unexpected", 64'(owner), 64'hFF);
                else check("grant_owner", 64'(owner), 64'(exp_gnt.pop_front()));
            end
            if (dc_valid && dc_ready) begin
                dc_cnt++;
                if (exp_dc.size() == 0) check("dc_unexpected", 64'd1, 64'd0);
                else begin
                    e = exp_dc.pop_front();
                    check("dc_data", dc_data, e.data);
                    check("dc_marks", {62'd0, dc_sop, dc_eop}, {62'd0, e.sop, e.eop});
                end
            end
            if (|(m_valid & m_ready)) begin
                out_cnt++;
                if (exp_out.size() == 0) check("out_unexpected", 64'd1, 64'd0);
                else begin
                    e = exp_out.pop_front();
                    check("out_m_valid", 64'(m_valid), 64'(4'b0001 << e.ch));
                    check("out_data", m_data, e.data);
                    check("out_marks", {62'd0, m_sop, m_eop}, {62'd0, e.sop, e.eop});
                    check("out_busy", 64'(busy), 64'd1);
                end
            end
        end
        busy_prev = busy;
    end

    // Source driver: retire accepted beats, present each channel's head beat
    always begin
        logic [NUM_CH-1:0] seen;
        @(posedge clk);
        #1;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (src_hs[c]) begin
                for (int j = 0; j < src_q.size(); j++) begin
                    if (src_q[j].ch == c) begin
                        src_q.delete(j);
                        break;
                    end
                end
            end
        end
        src_hs = '0;
        if (mr_toggle) m_rdy = ~m_rdy;
        m_ready = {NUM_CH{m_rdy}};
        seen    = '0;
        s_valid = '0;
        s_sop   = '0;
        s_eop   = '0;
        s_data  = '0;
        for (int j = 0; j < src_q.size(); j++) begin
            if (!seen[src_q[j].ch]) begin
                seen[src_q[j].ch]                     = 1'b1;
                s_valid[src_q[j].ch]                  = 1'b1;
                s_sop[src_q[j].ch]                    = src_q[j].sop;
                s_eop[src_q[j].ch]                    = src_q[j].eop;
                s_data[src_q[j].ch*DATA_W +: DATA_W]  = src_q[j].data;
            end
        end
    end

    task automatic send_pkt(input int ch, input int nbeats);
        beat_t b;
        logic [63:0] seed;
        seed = '0;
        for (int i = 0; i < nbeats; i++) begin
            b.ch   = ch;
            b.data = {8'(ch), 8'(pkt_no), 16'(i), 32'($urandom)};
            b.sop  = (i == 0);
            b.eop  = (i == nbeats - 1);
            if (i == 0) seed = b.data;
            src_q.push_back(b);
            exp_dc.push_back(b);
        end
        for (int k = 0; k < int'(BLK); k++) begin
            b.ch   = ch;
            b.data = dmodel(seed, k);
            b.sop  = (k == 0);
            b.eop  = (k == int'(BLK) - 1);
            exp_out.push_back(b);
        end
        exp_gnt.push_back(ch);
        pkt_no++;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int max_cyc);
        int  c;
        logic done;
        c    = 0;
        done = 1'b0;
        while (!done && c < max_cyc) begin
            step();
            c++;
            done = (src_q.size() == 0) && (exp_dc.size() == 0) && (exp_out.size() == 0)
                && (exp_gnt.size() == 0) && !busy;
        end
        check("wait_done", 64'(done), 64'd1);
    endtask

    initial begin
        int unsigned base_o, base_d;
        int c;
        rst_n   = 1'b0;
        s_valid = '0;
        s_sop   = '0;
        s_eop   = '0;
        s_data  = '0;
        m_ready = '1;

        // All four channels request together out of reset
        send_pkt(0, 3);
        send_pkt(1, 4);
        send_pkt(2, 2);
        send_pkt(3, 5);
        #3;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_owner", 64'(owner), 64'd0);
        check("rst_err_drop", 64'(err_drop), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_dc_valid", 64'(dc_valid), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_dco_ready", 64'(dco_ready), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_done(3000);

        // ch1 and ch3 after the pointer has wrapped back to 0
        send_pkt(1, 2);
        send_pkt(3, 3);
        wait_done(2000);

        // Single ch2 packet, 5 compressed beats
        base_o = out_cnt;
        base_d = dc_cnt;
        send_pkt(2, 5);
        wait_done(1000);
        check("ch2_dc_beats", 64'(dc_cnt - base_d), 64'd5);
        check("ch2_out_beats", 64'(out_cnt - base_o), 64'(BLK));

        // Decompressor input stall mid-FEED
        base_d = dc_cnt;
        send_pkt(0, 6);
        c = 0;
        while (dc_cnt < base_d + 2 && c < 50) begin
            step();
            c++;
        end
        check("stall_reached", 64'(dc_cnt >= base_d + 2), 64'd1);
        dc_rdy_knob = 1'b0;
        repeat (3) begin
            #1;
            check("stall_s_ready", 64'(s_ready), 64'd0);
            check("stall_busy", 64'(busy), 64'd1);
            step();
        end
        dc_rdy_knob = 1'b1;
        wait_done(1000);
        check("stall_dc_beats", 64'(dc_cnt - base_d), 64'd6);

        // Toggling downstream ready during DRAIN
        base_o    = out_cnt;
        mr_toggle = 1'b1;
        send_pkt(3, 4);
        wait_done(1000);
        mr_toggle = 1'b0;
        m_rdy     = 1'b1;
        check("toggle_out_beats", 64'(out_cnt - base_o), 64'(BLK));

        // Stray ch1 beat while idle
        begin
            beat_t b;
            b.ch   = 1;
            b.data = 64'hDEAD_BEEF_0000_0001;
            b.sop  = 1'b0;
            b.eop  = 1'b0;
            src_q.push_back(b);
        end
        c = 0;
        while (src_q.size() != 0 && c < 10) begin
            step();
            c++;
        end
        check("stray_accepted", 64'(src_q.size()), 64'd0);
        check("err_drop_pulse", 64'(err_drop), 64'd1);
        step();
        check("err_drop_clear", 64'(err_drop), 64'd0);
        check("stray_idle", 64'(busy), 64'd0);

        // Reset in the middle of DRAIN, then a clean ch0 packet
        base_o = out_cnt;
        send_pkt(2, 3);
        c = 0;
        while (out_cnt < base_o + 4 && c < 200) begin
            step();
            c++;
        end
        check("drain_reached", 64'(out_cnt >= base_o + 4), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_m_valid", 64'(m_valid), 64'd0);
        check("midrst_dco_ready", 64'(dco_ready), 64'd0);
        src_q.delete();
        exp_dc.delete();
        exp_out.delete();
        exp_gnt.delete();
        repeat (2) step();
        rst_n  = 1'b1;
        base_o = out_cnt;
        send_pkt(0, 4);
        wait_done(1000);
        check("post_rst_out_beats", 64'(out_cnt - base_o), 64'(BLK));
        check("post_rst_owner", 64'(owner), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
